// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one shared 33-bit adder, one iteration per clock.
// Optional MULDIV_EARLY_OUT_EN skips CALC for zero operands, divide-by-zero and div overflow.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNCT3,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int unsigned CntW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {StIdle, StPrep, StCalc, StFix} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     op1_q, op2_q, a_q, result_q;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [CntW-1:0]     cnt_q;
    logic                neg_q, dz_q, ovf_q, zero_q, done_q;

    logic                is_div, is_rem, s1, s2, div_zero, div_ovf, mul_zero, early;
    logic [XLEN-1:0]     mag1, mag2, fix_val, fix_res;
    logic [XLEN:0]       add_a, add_b, add_sum;
    logic                add_cin;

    assign is_div   = op_q[2];
    assign is_rem   = op_q[2] & op_q[1];
    // rs1 signed for MULH/MULHSU/DIV/REM, rs2 signed for MULH/DIV/REM
    assign s1 = op1_q[XLEN-1] & ((~op_q[2] & (op_q[1] ^ op_q[0])) | (op_q[2] & ~op_q[0]));
    assign s2 = op2_q[XLEN-1] & ((op_q == 3'b001) | (op_q[2] & ~op_q[0]));
    assign mag1 = s1 ? (~op1_q + XLEN'(1)) : op1_q;
    assign mag2 = s2 ? (~op2_q + XLEN'(1)) : op2_q;
    assign div_zero = is_div & (op2_q == '0);
    assign div_ovf  = is_div & ~op_q[0] & (op1_q == {1'b1, {(XLEN-1){1'b0}}}) & (op2_q == '1);
    assign mul_zero = ~is_div & ((op1_q == '0) | (op2_q == '0));

`ifdef MULDIV_EARLY_OUT_EN
    assign early = div_zero | div_ovf | mul_zero;
`else
    assign early = 1'b0;
`endif

    // Shared adder: add-shift in CALC (mul), trial subtract in CALC (div), negate in FIX.
    assign add_sum = add_a + add_b + {{XLEN{1'b0}}, add_cin};

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == StCalc) begin
            if (!is_div) begin
                add_a = {1'b0, prod_q[2*XLEN-1:XLEN]};
                add_b = prod_q[0] ? {1'b0, a_q} : '0;
            end else begin
                add_a   = prod_q[2*XLEN-1:XLEN-1];
                add_b   = ~{1'b0, a_q};
                add_cin = 1'b1;
            end
        end else if (state_q == StFix) begin
            add_a   = {1'b0, ~fix_val};
            // High word of a 64-bit negate takes the carry out of the negated low word
            add_cin = is_div ? 1'b1 : (prod_q[XLEN-1:0] == '0);
        end
    end

    always_comb begin
        if (!is_div) begin
            prod_d = {add_sum, prod_q[XLEN-1:1]};
        end else if (add_sum[XLEN]) begin
            prod_d = {prod_q[2*XLEN-2:0], 1'b0};
        end else begin
            prod_d = {add_sum[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        if (is_div) begin
            fix_val = is_rem ? prod_q[2*XLEN-1:XLEN] : prod_q[XLEN-1:0];
        end else begin
            fix_val = (op_q == 3'b000) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN];
        end
        if (ovf_q) begin
            fix_res = is_rem ? '0 : op1_q;
        end else if (dz_q) begin
            fix_res = is_rem ? op1_q : '1;
        end else if (zero_q) begin
            fix_res = '0;
        end else if (neg_q) begin
            fix_res = add_sum[XLEN-1:0];
        end else begin
            fix_res = fix_val;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (START && !FLUSH) state_d = StPrep;
            StPrep: state_d = FLUSH ? StIdle : (early ? StFix : StCalc);
            StCalc: begin
                if (FLUSH) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(1)) begin
                    state_d = StFix;
                end
            end
            StFix:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            op_q     <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            a_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (START && !FLUSH) begin
                        op_q  <= FUNCT3;
                        op1_q <= OPERAND1;
                        op2_q <= OPERAND2;
                    end
                end
                StPrep: begin
                    a_q    <= is_div ? mag2 : mag1;
                    prod_q <= {{XLEN{1'b0}}, is_div ? mag1 : mag2};
                    neg_q  <= is_rem ? s1 : (s1 ^ s2);
                    dz_q   <= div_zero;
                    ovf_q  <= div_ovf;
                    zero_q <= mul_zero;
                    cnt_q  <= CntW'(XLEN);
                end
                StCalc: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q - CntW'(1);
                end
                StFix: begin
                    if (!FLUSH) begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        BUSY   = (state_q != StIdle);
        DONE   = done_q;
        RESULT = result_q;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: scoreboard of expected results popped on DONE.
module tb_muldiv_sequencer;

    localparam int Lat = 34;

    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [2:0]  FUNCT3;
    logic [31:0] OPERAND1, OPERAND2;
    logic        BUSY, DONE;
    logic [31:0] RESULT;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] sb[$];
    logic [31:0] last_exp = '0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
        .OPERAND1(OPERAND1), .OPERAND2(OPERAND2), .FLUSH(FLUSH),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp[63:32];
            end
            3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : $signed(a) / $signed(b);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drive one request; returns at E0+1ns with START low and operands scrambled.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        @(negedge CLK);
        START = 1'b1; FUNCT3 = f; OPERAND1 = a; OPERAND2 = b;
        @(posedge CLK);
        #1;
        START = 1'b0; FUNCT3 = 3'($urandom); OPERAND1 = $urandom; OPERAND2 = $urandom;
        sb.push_back(exp);
    endtask

    task automatic wait_done(output int lat, output int busy_n, output bit seen);
        lat = 0; seen = 1'b0; busy_n = BUSY ? 1 : 0;
        while (lat < 100 && !seen) begin
            @(posedge CLK);
            #1;
            lat++;
            if (DONE === 1'b1) seen = 1'b1;
            else if (BUSY === 1'b1) busy_n++;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0; FUNCT3 = '0; OPERAND1 = '0; OPERAND2 = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", DONE); end
        n_cmp++;
        if (RESULT !== 32'h0) begin n_err++; $display("FAIL reset_result got %h want 0", RESULT); end
    endtask

    task automatic test_mul();
        logic [2:0]  f [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] a [4] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] b [4] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] e [4] = '{32'h2A, 32'h0, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        int lat, bn; bit seen; logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            issue(f[i], a[i], b[i], e[i]);
            wait_done(lat, bn, seen);
            exp = sb.pop_front();
            n_cmp++;
            if (!seen) begin n_err++; $display("FAIL mul_done[%0d] no DONE within 100 cycles", i); end
            n_cmp++;
            if (RESULT !== exp) begin n_err++; $display("FAIL mul_result[%0d] got %h want %h", i, RESULT, exp); end
            n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL mul_busy_at_done[%0d] got %b want 0", i, BUSY); end
`ifndef MULDIV_EARLY_OUT_EN
            n_cmp++; if (lat != Lat) begin n_err++; $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, Lat); end
            n_cmp++; if (bn != Lat) begin n_err++; $display("FAIL mul_busy_cycles[%0d] got %0d want %0d", i, bn, Lat); end
`endif
            last_exp = exp;
        end
    endtask

    task automatic test_div();
        logic [2:0]  f [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] a [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] b [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] e [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        int lat, bn; bit seen; logic [31:0] exp;
        for (int i = 0; i < 4; i++) begin
            issue(f[i], a[i], b[i], e[i]);
            wait_done(lat, bn, seen);
            exp = sb.pop_front();
            n_cmp++;
            if (!seen) begin n_err++; $display("FAIL div_done[%0d] no DONE within 100 cycles", i); end
            n_cmp++;
            if (RESULT !== exp) begin n_err++; $display("FAIL div_result[%0d] got %h want %h", i, RESULT, exp); end
`ifndef MULDIV_EARLY_OUT_EN
            n_cmp++; if (lat != Lat) begin n_err++; $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, Lat); end
`endif
            last_exp = exp;
        end
    endtask

    task automatic test_special();
        logic [2:0]  f [7] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd0};
        logic [31:0] a [7] = '{32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000,
                               32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h0};
        logic [31:0] b [7] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h1234};
        logic [31:0] e [7] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0,
                               32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0};
        int lat, bn; bit seen; logic [31:0] exp;
        for (int i = 0; i < 7; i++) begin
            issue(f[i], a[i], b[i], e[i]);
            wait_done(lat, bn, seen);
            exp = sb.pop_front();
            n_cmp++;
            if (!seen) begin n_err++; $display("FAIL special_done[%0d] no DONE within 100 cycles", i); end
            n_cmp++;
            if (RESULT !== exp) begin n_err++; $display("FAIL special_result[%0d] got %h want %h", i, RESULT, exp); end
`ifndef MULDIV_EARLY_OUT_EN
            n_cmp++; if (lat != Lat) begin n_err++; $display("FAIL special_latency[%0d] got %0d want %0d", i, lat, Lat); end
`endif
            last_exp = exp;
        end
    endtask

    task automatic test_flush();
        int lat, bn; bit seen; logic [31:0] exp;
        issue(3'd0, 32'd3, 32'd3, 32'd9);
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1; START = 1'b1; FUNCT3 = 3'd5; OPERAND1 = 32'd50; OPERAND2 = 32'd5;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0; START = 1'b0;
        sb.delete();
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL flush_idle got BUSY=%b want 0", BUSY); end
        seen = 1'b0;
        repeat (40) begin @(posedge CLK); #1; if (DONE === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen) begin n_err++; $display("FAIL flush_no_done got DONE=1 want none"); end
        n_cmp++;
        if (RESULT !== last_exp) begin n_err++; $display("FAIL flush_result got %h want %h", RESULT, last_exp); end
        // FLUSH together with START in IDLE drops the request
        @(negedge CLK);
        FLUSH = 1'b1; START = 1'b1; FUNCT3 = 3'd0; OPERAND1 = 32'd5; OPERAND2 = 32'd5;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0; START = 1'b0;
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL flush_start_idle got BUSY=%b want 0", BUSY); end
        issue(3'd5, 32'd9, 32'd3, 32'd3);
        wait_done(lat, bn, seen);
        exp = sb.pop_front();
        n_cmp++; if (!seen) begin n_err++; $display("FAIL flush_next_done no DONE within 100 cycles"); end
        n_cmp++;
        if (RESULT !== exp) begin n_err++; $display("FAIL flush_next_result got %h want %h", RESULT, exp); end
`ifndef MULDIV_EARLY_OUT_EN
        n_cmp++; if (lat != Lat) begin n_err++; $display("FAIL flush_next_latency got %0d want %0d", lat, Lat); end
`endif
        last_exp = exp;
    endtask

    // Each new START is driven in the DONE cycle of the previous operation.
    task automatic test_back_to_back();
        int lat, bn; bit seen; logic [31:0] exp, a, b; logic [2:0] f;
        for (int i = 0; i < 8; i++) begin
            f = 3'(i); a = $urandom; b = (i == 5) ? 32'd0 : $urandom;
            if (i >= 4 && i != 5) b = b >> (i * 3);
            issue(f, a, b, model(f, a, b));
            wait_done(lat, bn, seen);
            exp = sb.pop_front();
            n_cmp++;
            if (!seen) begin n_err++; $display("FAIL b2b_done[%0d] no DONE within 100 cycles", i); end
            n_cmp++;
            if (RESULT !== exp) begin
                n_err++;
                $display("FAIL b2b_result[%0d] f=%0d a=%h b=%h got %h want %h", i, f, a, b, RESULT, exp);
            end
            last_exp = exp;
        end
    endtask

    task automatic test_start_ignored();
        int lat, bn; bit seen; logic [31:0] exp;
        issue(3'd3, 32'hDEAD_BEEF, 32'h0000_1000, model(3'd3, 32'hDEAD_BEEF, 32'h0000_1000));
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(posedge CLK);
            @(negedge CLK);
            START = 1'b1; FUNCT3 = 3'd0; OPERAND1 = 32'd1; OPERAND2 = 32'd1;
            @(negedge CLK);
            START = 1'b0;
        end
        wait_done(lat, bn, seen);
        exp = sb.pop_front();
        n_cmp++; if (!seen) begin n_err++; $display("FAIL ignore_done no DONE within 100 cycles"); end
        n_cmp++;
        if (RESULT !== exp) begin n_err++; $display("FAIL ignore_result got %h want %h", RESULT, exp); end
        last_exp = exp;
        seen = 1'b0;
        repeat (40) begin @(posedge CLK); #1; if (DONE === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen) begin n_err++; $display("FAIL ignore_second_done got DONE=1 want none"); end
    endtask

    task automatic test_reset_mid();
        int lat, bn; bit seen; logic [31:0] exp;
        issue(3'd1, 32'h7654_3210, 32'h0123_4567, 32'h0);
        repeat (15) @(posedge CLK);
        #2;
        RESET = 1'b1;
        #1;
        sb.delete();
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", DONE); end
        n_cmp++;
        if (RESULT !== 32'h0) begin n_err++; $display("FAIL rstmid_result got %h want 0", RESULT); end
        @(negedge CLK);
        RESET = 1'b0;
        issue(3'd7, 32'd1000, 32'd33, 32'd10);
        wait_done(lat, bn, seen);
        exp = sb.pop_front();
        n_cmp++; if (!seen) begin n_err++; $display("FAIL rstmid_next_done no DONE within 100 cycles"); end
        n_cmp++;
        if (RESULT !== exp) begin n_err++; $display("FAIL rstmid_next_result got %h want %h", RESULT, exp); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
